// File: rtl/regfile_read_port.sv
// 32-entry register file with one-hot write enable, write-address re-encode and a dual registered read port.
// Read latency is one cycle from accepted rdReq to rdValid; a bypass returns same-cycle write data (write-first).
// A held result (rdValid & !rdAck) stalls new requests via rdBusy. Define ZERO_REG_EN to hard-wire register 0 to zero.
module regfile_read_port #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      FF_en,
  input  logic [WIDTH-1:0] wD,
  input  logic             rdReq,
  input  logic [4:0]       rA,
  input  logic [4:0]       rB,
  input  logic             rdAck,
  output logic             rdValid,
  output logic [WIDTH-1:0] rdDataA,
  output logic [WIDTH-1:0] rdDataB,
  output logic             rdBusy,
  output logic [4:0]       lastWA,
  output logic             wrSeen,
  output logic             onehotErr
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state;
  logic [WIDTH-1:0] regs [32];
  logic [31:0]      wr_mask;
  logic             multi_hot;
  logic [4:0]       enc_wa;
  logic             accept;
  logic [WIDTH-1:0] rd_a_nxt;
  logic [WIDTH-1:0] rd_b_nxt;

  // Register 0 writes are dropped before they reach storage or the error check.
`ifdef ZERO_REG_EN
  assign wr_mask = FF_en & 32'hFFFF_FFFE;
`else
  assign wr_mask = FF_en;
`endif

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_hot = |(wr_mask & (wr_mask - 32'd1));

  always_comb begin
    enc_wa = '0;
    for (int i = 0; i < 32; i++) begin
      if (FF_en[i]) enc_wa = 5'(i);
    end
  end

  assign rdValid = (state == FULL);
  assign rdBusy  = rdValid & ~rdAck;
  assign accept  = rdReq & (~rdValid | rdAck);

  always_comb begin
    rd_a_nxt = wr_mask[rA] ? wD : regs[rA];
    rd_b_nxt = wr_mask[rB] ? wD : regs[rB];
`ifdef ZERO_REG_EN
    if (rA == 5'd0) rd_a_nxt = '0;
    if (rB == 5'd0) rd_b_nxt = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= RESET_VAL;
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (wr_mask[i]) regs[i] <= wD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lastWA    <= '0;
      wrSeen    <= 1'b0;
      onehotErr <= 1'b0;
    end else begin
      if (FF_en != 32'd0) begin
        lastWA <= enc_wa;
        wrSeen <= 1'b1;
      end
      if (multi_hot) onehotErr <= 1'b1;
    end
  end

  // Output stage: the captured pair is a snapshot and only changes on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      rdDataA <= '0;
      rdDataB <= '0;
    end else begin
      if (accept) begin
        state   <= FULL;
        rdDataA <= rd_a_nxt;
        rdDataB <= rd_b_nxt;
      end else if (rdAck) begin
        state <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_regfile_read_port.sv
// Bench for regfile_read_port: directed vector table, stall and mid-operation reset sequences, then random traffic vs a reference model.
module tb_regfile_read_port;

`ifdef ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] FF_en = '0;
  logic [31:0] wD = '0;
  logic        rdReq = 1'b0;
  logic [4:0]  rA = '0;
  logic [4:0]  rB = '0;
  logic        rdAck = 1'b0;
  logic        rdValid;
  logic [31:0] rdDataA;
  logic [31:0] rdDataB;
  logic        rdBusy;
  logic [4:0]  lastWA;
  logic        wrSeen;
  logic        onehotErr;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_read_port #(.WIDTH(32), .RESET_VAL(32'd0)) dut (
    .clk(clk), .rst_n(rst_n), .FF_en(FF_en), .wD(wD), .rdReq(rdReq), .rA(rA), .rB(rB),
    .rdAck(rdAck), .rdValid(rdValid), .rdDataA(rdDataA), .rdDataB(rdDataB), .rdBusy(rdBusy),
    .lastWA(lastWA), .wrSeen(wrSeen), .onehotErr(onehotErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [31:0] en, input logic [31:0] wd, input logic req,
                       input logic [4:0] a, input logic [4:0] b, input logic ack);
    FF_en = en; wD = wd; rdReq = req; rA = a; rB = b; rdAck = ack;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model (spec-level) ----------------
  logic [31:0] mregs [32];
  logic        m_valid;
  logic [31:0] m_a, m_b;
  logic [4:0]  m_lwa;
  logic        m_seen, m_err;

  task automatic m_reset();
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    m_valid = 0; m_a = 0; m_b = 0; m_lwa = 0; m_seen = 0; m_err = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] adr, input logic [31:0] en, input logic [31:0] wd);
    if (ZR && adr == 5'd0) return 32'd0;
    if (en[adr]) return wd;
    return mregs[adr];
  endfunction

  task automatic m_step(input logic [31:0] en, input logic [31:0] wd, input logic req,
                        input logic [4:0] a, input logic [4:0] b, input logic ack);
    logic [31:0] counted;
    if (req && (!m_valid || ack)) begin
      m_a = m_read(a, en, wd);
      m_b = m_read(b, en, wd);
      m_valid = 1;
    end else if (ack) begin
      m_valid = 0;
    end
    for (int i = 0; i < 32; i++)
      if (en[i] && !(ZR && i == 0)) mregs[i] = wd;
    counted = ZR ? (en & 32'hFFFF_FFFE) : en;
    if ($countones(counted) > 1) m_err = 1;
    if (en != 0) begin
      m_lwa  = 5'($clog2({1'b0, en} + 33'd1) - 1);
      m_seen = 1;
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0] en, wd;
    logic        req;
    logic [4:0]  a, b;
    logic        ack;
    logic        e_busy, e_valid;
    logic [31:0] e_a, e_b;
    logic [4:0]  e_lwa;
    logic        e_seen, e_err;
  } vec_t;

  vec_t vecs [9];

  initial begin
    logic [31:0] r0v, r0w;
    logic [31:0] hold_a, hold_b;
    r0v = ZR ? 32'd0 : 32'd7;
    r0w = ZR ? 32'd0 : 32'h0000_FFFF;

    //           en            wd            req a   b   ack busy vld A             B             lwa seen err
    vecs[0] = '{32'h0,         32'h0,         1, 5,  31, 0,  0,  1, 32'h0,         32'h0,         0,  0,  0};
    vecs[1] = '{32'h0000_0020, 32'hDEAD_BEEF, 0, 0,  0,  1,  0,  0, 32'h0,         32'h0,         5,  1,  0};
    vecs[2] = '{32'h0,         32'h0,         1, 5,  0,  0,  0,  1, 32'hDEAD_BEEF, 32'h0,         5,  1,  0};
    vecs[3] = '{32'h0000_0100, 32'h1234_5678, 1, 8,  8,  1,  0,  1, 32'h1234_5678, 32'h1234_5678, 8,  1,  0};
    vecs[4] = '{32'h8000_0003, 32'd7,         1, 1,  31, 1,  0,  1, 32'd7,         32'd7,         31, 1,  1};
    vecs[5] = '{32'h0,         32'h0,         1, 0,  31, 1,  0,  1, r0v,           32'd7,         31, 1,  1};
    vecs[6] = '{32'h0,         32'h0,         0, 0,  0,  1,  0,  0, r0v,           32'd7,         31, 1,  1};
    vecs[7] = '{32'h0,         32'h0,         0, 3,  4,  1,  0,  0, r0v,           32'd7,         31, 1,  1};
    vecs[8] = '{32'h0000_0001, 32'h0000_FFFF, 1, 0,  0,  0,  0,  1, r0w,           r0w,           0,  1,  1};

    // Reset state
    drive(0, 0, 0, 0, 0, 0);
    #12;
    chk("reset_valid", rdValid, 0);
    chk("reset_dataA", rdDataA, 0);
    chk("reset_dataB", rdDataB, 0);
    chk("reset_lastwa", lastWA, 0);
    chk("reset_wrseen", wrSeen, 0);
    chk("reset_err", onehotErr, 0);
    chk("reset_busy", rdBusy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].en, vecs[i].wd, vecs[i].req, vecs[i].a, vecs[i].b, vecs[i].ack);
      #1;
      chk($sformatf("vec%0d_busy", i), rdBusy, vecs[i].e_busy);
      tick();
      chk($sformatf("vec%0d_valid", i), rdValid, vecs[i].e_valid);
      chk($sformatf("vec%0d_dataA", i), rdDataA, vecs[i].e_a);
      chk($sformatf("vec%0d_dataB", i), rdDataB, vecs[i].e_b);
      chk($sformatf("vec%0d_lastwa", i), lastWA, vecs[i].e_lwa);
      chk($sformatf("vec%0d_wrseen", i), wrSeen, vecs[i].e_seen);
      chk($sformatf("vec%0d_err", i), onehotErr, vecs[i].e_err);
    end

    // Output stall: result held while requests and rewrites of the target continue.
    hold_a = r0w;
    hold_b = r0w;
    for (int k = 0; k < 3; k++) begin
      drive(32'h0000_0100, 32'hA5A5_A5A5, 1, 8, 8, 0);
      #1;
      chk($sformatf("stall%0d_busy", k), rdBusy, 1);
      tick();
      chk($sformatf("stall%0d_valid", k), rdValid, 1);
      chk($sformatf("stall%0d_dataA", k), rdDataA, hold_a);
      chk($sformatf("stall%0d_dataB", k), rdDataB, hold_b);
    end
    drive(0, 0, 1, 8, 8, 1);
    #1;
    chk("unstall_busy", rdBusy, 0);
    tick();
    chk("unstall_valid", rdValid, 1);
    chk("unstall_dataA", rdDataA, 32'hA5A5_A5A5);
    chk("unstall_dataB", rdDataB, 32'hA5A5_A5A5);
    chk("unstall_lastwa", lastWA, 8);
    drive(0, 0, 0, 0, 0, 0);

    // Reset mid-operation: outputs clear before any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", rdValid, 0);
    chk("midrst_dataA", rdDataA, 0);
    chk("midrst_dataB", rdDataB, 0);
    chk("midrst_err", onehotErr, 0);
    chk("midrst_wrseen", wrSeen, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    drive(0, 0, 1, 8, 31, 0);
    tick();
    chk("postrst_valid", rdValid, 1);
    chk("postrst_dataA", rdDataA, 0);
    chk("postrst_dataB", rdDataB, 0);

    // Random traffic against the reference model.
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #3;
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int c = 0; c < 600; c++) begin
      logic [31:0] en, wd;
      logic        req, ack;
      logic [4:0]  a, b;
      int          sel;
      sel = $urandom_range(0, 99);
      if (sel < 40)      en = 32'd0;
      else if (sel < 97) en = 32'd1 << $urandom_range(0, 31);
      else               en = $urandom;
      wd  = $urandom;
      req = ($urandom_range(0, 3) != 0);
      ack = ($urandom_range(0, 2) != 0);
      a   = 5'($urandom_range(0, 31));
      b   = ($urandom_range(0, 4) == 0) ? a : 5'($urandom_range(0, 31));
      if (en != 0 && $urandom_range(0, 2) == 0) a = 5'($clog2({1'b0, en} + 33'd1) - 1);
      drive(en, wd, req, a, b, ack);
      #1;
      chk("rnd_busy", rdBusy, m_valid && !ack);
      m_step(en, wd, req, a, b, ack);
      tick();
      chk("rnd_valid", rdValid, m_valid);
      if (m_valid) begin
        chk("rnd_dataA", rdDataA, m_a);
        chk("rnd_dataB", rdDataB, m_b);
      end
      chk("rnd_lastwa", lastWA, m_lwa);
      chk("rnd_wrseen", wrSeen, m_seen);
      chk("rnd_err", onehotErr, m_err);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
